cla_word_sequencer: RTL and testbench

//   Multi-precision add/subtract controller for the 16-bit carry look-ahead adder (CLA).

---
 rtl/cla_word_sequencer.sv | 117 +++++++++++
 tb/tb_cla_word_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// Multi-precision add/subtract sequencer: streams a wide operand pair through one
// external WORD_W-bit carry look-ahead adder, LS slice first, rippling carry in a register.
module cla_word_sequencer #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   in_a,
  input  logic [WORD_W*NUM_WORDS-1:0]   in_b,
  input  logic                          in_cin,
  input  logic                          in_sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   out_sum,
  output logic                          out_cout,
  output logic                          out_ovf,
  output logic [WORD_W-1:0]             cla_a,
  output logic [WORD_W-1:0]             cla_b,
  output logic                          cla_cin,
  input  logic [WORD_W-1:0]             cla_sum,
  input  logic                          cla_cout
);

  localparam int DW    = WORD_W * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW+WORD_W-1:0] sum_shift;
  logic              last_slice;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Operands shift right one slice per RUN cycle so the CLA always sees the low slice;
  // result slices enter at the top and land in place after NUM_WORDS shifts.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    cla_a      = '0;
    cla_b      = '0;
    cla_cin    = 1'b0;
    last_slice = (idx_q == IDX_W'(NUM_WORDS - 1));
    sum_shift  = {cla_sum, sum_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cla_a   = a_q[WORD_W-1:0];
        cla_b   = b_q[WORD_W-1:0];
        cla_cin = carry_q;
        a_d     = a_q >> WORD_W;
        b_d     = b_q >> WORD_W;
        sum_d   = sum_shift[DW+WORD_W-1:WORD_W];
        carry_d = cla_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          // Top slice carries the sign bits of A and B'.
          cout_d  = cla_cout;
          ovf_d   = (cla_a[WORD_W-1] == cla_b[WORD_W-1]) &&
                    (cla_sum[WORD_W-1] != cla_a[WORD_W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Scoreboard bench for cla_word_sequencer: a stimulus driver, an arithmetic reference
// model, and an independent monitor that checks every result handshake.
module tb_cla_word_sequencer;

  localparam int WW = 16;
  localparam int NW = 4;
  localparam int DW = WW * NW;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_cin, in_sub;
  logic [DW-1:0] in_a, in_b;
  logic          out_valid, out_ready, out_cout, out_ovf;
  logic [DW-1:0] out_sum;
  logic [WW-1:0] cla_a, cla_b, cla_sum;
  logic          cla_cin, cla_cout;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic [31:0]   acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   prev_v = 1'b0;
  bit   bp_rand = 1'b0;

  cla_word_sequencer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
  );

  // Combinational 16-bit CLA stand-in
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {{WW{1'b0}}, cla_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic; overflow when the true signed result
  // does not fit in DW bits.
  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic sub);
    exp_t          e;
    logic [DW+1:0] sa, sb_x, s, u;
    sa   = {{2{a[DW-1]}}, a};
    sb_x = {{2{b[DW-1]}}, b};
    if (sub) begin
      u      = {2'b00, a} - {2'b00, b};
      e.cout = (a >= b);
      s      = sa - sb_x;
    end else begin
      u      = {2'b00, a} + {2'b00, b} + {{(DW+1){1'b0}}, cin};
      e.cout = u[DW];
      s      = sa + sb_x + {{(DW+1){1'b0}}, cin};
    end
    e.sum = u[DW-1:0];
    e.ovf = (s != {{2{e.sum[DW-1]}}, e.sum});
    e.acc = '0;
    return e;
  endfunction

  // Monitor: records accepted operations and checks every presented result
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid got 1 expected 0");
        end else begin
          check("latency", DW'(cyc - int'(sb[0].acc)), DW'(NW));
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_cout", DW'(out_cout), DW'(e.cout));
        check("out_ovf", DW'(out_ovf), DW'(e.ovf));
      end
      prev_v = out_valid;
      if (in_valid && in_ready) begin
        e     = model(in_a, in_b, in_cin, in_sub);
        e.acc = 32'(cyc + 1);
        sb.push_back(e);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic sub);
    bit got = 1'b0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = {1'b1, {(DW-1){1'b0}}};
    corners[3] = {1'b0, {(DW-1){1'b1}}};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    exp_t e;
    bit   seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_reset", DW'(in_ready), '0);
    check("out_sum_reset", out_sum, '0);
    rst_n = 1'b1;
    #1;
    check("in_ready_idle", DW'(in_ready), DW'(1));
    check("out_valid_reset", DW'(out_valid), '0);
    check("out_cout_reset", DW'(out_cout), '0);
    check("out_ovf_reset", DW'(out_ovf), '0);
    check("cla_idle", {cla_a, cla_b, 31'd0, cla_cin}, '0);
    @(posedge clk); #1;

    send(64'd3, 64'd2, 1'b0, 1'b0);
    drain();

    send('1, '0, 1'b1, 1'b0);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      check("ripple_cla_cin", DW'(cla_cin), DW'(1));
    end
    drain();

    // Back-to-back source: sequencer must stall between operations
    send(64'd100, 64'd200, 1'b0, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'd0, 64'd1, 1'b0, 1'b1);
    drain();

    // Backpressure in DONE with a competing request held on the input
    out_ready = 1'b0;
    in_a = pick(); in_b = pick();
    e = model(in_a, in_b, 1'b0, 1'b0);
    send(in_a, in_b, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid_rise", DW'(seen), DW'(1));
    @(posedge clk); #1;
    in_a = 64'd11; in_b = 64'd22; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", DW'(out_valid), DW'(1));
      check("bp_out_sum", out_sum, e.sum);
      check("bp_in_ready", DW'(in_ready), '0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'd11, 64'd22, 1'b0, 1'b0);
    drain();

    // Reset asserted in the third RUN cycle
    send(pick(), pick(), 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("in_ready_mid_reset", DW'(in_ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_out_valid", DW'(out_valid), '0);
    check("abort_out_sum", out_sum, '0);
    check("abort_cla", {cla_a, cla_b, 31'd0, cla_cin}, '0);
    check("abort_in_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", DW'(out_valid), '0);
    end
    @(posedge clk); #1;
    send(64'd255, 64'd255, 1'b0, 1'b0);
    drain();

    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    bp_rand = 1'b0;
    out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
